// File: rtl/axi_log_drain.sv
// Bulk drain of N 96-bit logger entries from the BRAM read port, serialised as id/len, address, timestamp words.
// Latency: Start -> BramEn 1 cycle, -> first word 2+BRAM_RD_LAT cycles; OutReady_SI low holds data/valid stable.
// Define AXI_LOG_DRAIN_HEADER_EN to emit a {16'hB10C, N} header word before the first entry.
module axi_log_drain #(
    parameter int LOGGING_DATA_BITW = 96,
    parameter int NUM_SER_BRAMS     = 12,
    parameter int LOG_ADDR_BITW     = $clog2(1024*NUM_SER_BRAMS) + 2,
    parameter int CNT_BITW          = LOG_ADDR_BITW - 1,
    parameter int BRAM_RD_LAT       = 1
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RI,
    input  logic                         Start_SI,
    input  logic                         Abort_SI,
    input  logic [CNT_BITW-1:0]          NumEntries_DI,
    output logic                         BramEn_SO,
    output logic [LOG_ADDR_BITW-1:0]     BramAddr_DO,
    input  logic [LOGGING_DATA_BITW-1:0] BramRdData_DI,
    output logic [31:0]                  OutData_DO,
    output logic                         OutValid_SO,
    input  logic                         OutReady_SI,
    output logic                         Busy_SO,
    output logic                         Done_SO
);

    localparam int MAX_ENTRIES = 1024 * NUM_SER_BRAMS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_BITW-1:0]          remaining_q, remaining_d;
    logic [CNT_BITW-1:0]          index_q, index_d;
    logic [1:0]                   word_sel_q, word_sel_d;
    logic [1:0]                   wait_cnt_q, wait_cnt_d;
    logic [LOGGING_DATA_BITW-1:0] hold_q, hold_d;
`ifdef AXI_LOG_DRAIN_HEADER_EN
    logic                         hdr_q, hdr_d;
`endif

    logic [CNT_BITW-1:0] num_clamped;
    logic                handshake;
    logic                wait_last;
    logic                last_word;

    assign num_clamped = (NumEntries_DI > CNT_BITW'(MAX_ENTRIES)) ? CNT_BITW'(MAX_ENTRIES)
                                                                  : NumEntries_DI;
    assign handshake   = OutValid_SO && OutReady_SI;
    assign wait_last   = (wait_cnt_q == 2'(BRAM_RD_LAT - 1));
    assign last_word   = (word_sel_q == 2'd2);

    // State and datapath registers
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            index_q     <= '0;
            word_sel_q  <= '0;
            wait_cnt_q  <= '0;
            hold_q      <= '0;
`ifdef AXI_LOG_DRAIN_HEADER_EN
            hdr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            word_sel_q  <= word_sel_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_q      <= hold_d;
`ifdef AXI_LOG_DRAIN_HEADER_EN
            hdr_q       <= hdr_d;
`endif
        end
    end

    // Next-state logic; abort overrides everything, including a same-cycle handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start_SI) begin
`ifdef AXI_LOG_DRAIN_HEADER_EN
                    state_d = S_SEND;
`else
                    state_d = (num_clamped == '0) ? S_DONE : S_READ;
`endif
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_last) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (handshake) begin
`ifdef AXI_LOG_DRAIN_HEADER_EN
                    if (hdr_q) begin
                        state_d = (remaining_q == '0) ? S_DONE : S_READ;
                    end else
`endif
                    if (last_word) begin
                        state_d = (remaining_q == CNT_BITW'(1)) ? S_DONE : S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Abort_SI && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        remaining_d = remaining_q;
        index_d     = index_q;
        word_sel_d  = word_sel_q;
        wait_cnt_d  = wait_cnt_q;
        hold_d      = hold_q;
`ifdef AXI_LOG_DRAIN_HEADER_EN
        hdr_d       = hdr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start_SI) begin
                    remaining_d = num_clamped;
                    index_d     = '0;
                    word_sel_d  = '0;
`ifdef AXI_LOG_DRAIN_HEADER_EN
                    hdr_d       = 1'b1;
`endif
                end
            end
            S_READ: wait_cnt_d = '0;
            S_WAIT: begin
                if (wait_last) begin
                    hold_d     = BramRdData_DI;
                    word_sel_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_SEND: begin
                if (handshake && !Abort_SI) begin
`ifdef AXI_LOG_DRAIN_HEADER_EN
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                    end else
`endif
                    if (last_word) begin
                        word_sel_d  = '0;
                        index_d     = index_q + CNT_BITW'(1);
                        remaining_d = remaining_q - CNT_BITW'(1);
                    end else begin
                        word_sel_d = word_sel_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs are pure functions of state, so reset/abort zero them on the next cycle
    always_comb begin
        BramEn_SO   = 1'b0;
        BramAddr_DO = '0;
        OutValid_SO = 1'b0;
        OutData_DO  = '0;
        Busy_SO     = (state_q != S_IDLE);
        Done_SO     = (state_q == S_DONE);
        case (state_q)
            S_READ: begin
                BramEn_SO   = 1'b1;
                BramAddr_DO = {index_q[LOG_ADDR_BITW-3:0], 2'b00};
            end
            S_SEND: begin
                OutValid_SO = 1'b1;
                case (word_sel_q)
                    2'd0:    OutData_DO = hold_q[31:0];
                    2'd1:    OutData_DO = hold_q[63:32];
                    2'd2:    OutData_DO = hold_q[95:64];
                    default: OutData_DO = '0;
                endcase
`ifdef AXI_LOG_DRAIN_HEADER_EN
                if (hdr_q) begin
                    OutData_DO = {16'hB10C, 16'(remaining_q)};
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_log_drain.sv
// Directed bench for axi_log_drain: BRAM model with read latency, word/address scoreboards, stall/abort/reset cases.
module tb_axi_log_drain;

    localparam int LAT  = 2;
    localparam int MAXE = 12288;
    localparam int AW   = 16;
    localparam int CW   = 15;
`ifdef AXI_LOG_DRAIN_HEADER_EN
    localparam int HW = 1;
`else
    localparam int HW = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort, ready;
    logic [CW-1:0] num;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [95:0]   rd_data;
    logic [31:0]   out_data;
    logic          out_vld, busy, done;

    always #5 clk = ~clk;

    axi_log_drain #(.BRAM_RD_LAT(LAT)) dut (
        .Clk_CI        (clk),
        .Rst_RI        (rst),
        .Start_SI      (start),
        .Abort_SI      (abort),
        .NumEntries_DI (num),
        .BramEn_SO     (bram_en),
        .BramAddr_DO   (bram_addr),
        .BramRdData_DI (rd_data),
        .OutData_DO    (out_data),
        .OutValid_SO   (out_vld),
        .OutReady_SI   (ready),
        .Busy_SO       (busy),
        .Done_SO       (done)
    );

    // BRAM model: data is valid only LAT cycles after an enable, poison otherwise
    logic [95:0] mem  [MAXE];
    logic [95:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= bram_en ? mem[bram_addr[AW-1:2]] : {3{32'hDEADBEEF}};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[LAT-1];

    int            checks = 0;
    int            errors = 0;
    int            words_seen = 0;
    int            done_cnt = 0;
    logic [31:0]   exp_w[$];
    logic [AW-1:0] exp_a[$];
    logic          prev_stall = 1'b0;
    logic          prev_done  = 1'b0;
    logic [31:0]   prev_data  = '0;
    logic [AW-1:0] last_addr  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (prev_done) chk("busy_after_done", 64'(busy), 64'(0));
        if (prev_stall) begin
            chk("stall_valid", 64'(out_vld), 64'(1));
            chk("stall_data", 64'(out_data), 64'(prev_data));
        end
        if (bram_en) begin
            last_addr = bram_addr;
            if (exp_a.size() == 0) chk("bram_read_unexpected", 64'(bram_en), 64'(0));
            else                   chk("bram_addr", 64'(bram_addr), 64'(exp_a.pop_front()));
        end
        if (out_vld && ready && !abort && !rst) begin
            words_seen++;
            if (exp_w.size() == 0) chk("word_unexpected", 64'(out_vld), 64'(0));
            else                   chk("word", 64'(out_data), 64'(exp_w.pop_front()));
        end
        if (done) done_cnt++;
        prev_done  = done;
        prev_stall = out_vld && !ready && !abort && !rst;
        prev_data  = out_data;
    endtask

    // Called at a negedge with inputs already set for the coming posedge
    task automatic step();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_drain(input int n);
        int ne;
        logic [95:0] w;
        ne = (n > MAXE) ? MAXE : n;
`ifdef AXI_LOG_DRAIN_HEADER_EN
        exp_w.push_back({16'hB10C, 16'(ne)});
`endif
        for (int i = 0; i < ne; i++) begin
            w = mem[i];
            exp_a.push_back(AW'(i << 2));
            exp_w.push_back(w[31:0]);
            exp_w.push_back(w[63:32]);
            exp_w.push_back(w[95:64]);
        end
    endtask

    task automatic start_drain(input int n);
        push_drain(n);
        num   = CW'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        num   = '1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int c;
        d0 = done_cnt;
        c  = 0;
        while (done_cnt == d0 && c < budget) begin
            step();
            c++;
        end
        chk(tag, 64'(done_cnt - d0), 64'(1));
    endtask

    initial begin
        int w0, d0, c, hold;
        for (int i = 0; i < MAXE; i++)
            mem[i] = {32'h10 + 32'(i), 32'h8000_0000 | (32'(i) << 6), 32'(i) * 32'h0001_0003 + 32'h305};
        mem[0] = {32'h10, 32'h8000_0040, 32'h0000_0305};
        mem[1] = {32'h11, 32'h8000_1000, 32'h0000_0F07};
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; num = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_bram_en", 64'(bram_en), 64'(0));
        chk("rst_bram_addr", 64'(bram_addr), 64'(0));
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        step();

        // Two entries, ready held high
        w0 = words_seen; d0 = done_cnt;
        start_drain(2);
`ifndef AXI_LOG_DRAIN_HEADER_EN
        chk("lat_bram_en", 64'(bram_en), 64'(1));
        chk("lat_addr0", 64'(bram_addr), 64'(0));
        repeat (LAT) step();
        chk("lat_not_yet_valid", 64'(out_vld), 64'(0));
        step();
        chk("lat_first_valid", 64'(out_vld), 64'(1));
        chk("lat_first_word", 64'(out_data), 64'(32'h305));
`endif
        wait_done(60, "t1_done");
        repeat (3) step();
        chk("t1_words", 64'(words_seen - w0), 64'(6 + HW));
        chk("t1_queue_empty", 64'(exp_w.size()), 64'(0));
        chk("t1_single_done", 64'(done_cnt - d0), 64'(1));

        // Same data with ready toggling and a 5-cycle stall on word 1
        w0 = words_seen; d0 = done_cnt; hold = 0; c = 0;
        start_drain(2);
        while (done_cnt == d0 && c < 200) begin
            if (words_seen - w0 == HW + 1 && out_vld && hold < 5) begin
                ready = 1'b0;
                hold++;
            end else begin
                ready = (c % 2 == 0);
            end
            step();
            c++;
        end
        ready = 1'b1;
        chk("t2_done", 64'(done_cnt - d0), 64'(1));
        chk("t2_words", 64'(words_seen - w0), 64'(6 + HW));
        chk("t2_queue_empty", 64'(exp_w.size()), 64'(0));
        step();

        // Zero entries
        w0 = words_seen; d0 = done_cnt;
        start_drain(0);
`ifndef AXI_LOG_DRAIN_HEADER_EN
        chk("n0_done_pulse", 64'(done), 64'(1));
        chk("n0_no_valid", 64'(out_vld), 64'(0));
        chk("n0_no_bram", 64'(bram_en), 64'(0));
`else
        wait_done(20, "n0_done");
`endif
        repeat (3) step();
        chk("n0_done_count", 64'(done_cnt - d0), 64'(1));
        chk("n0_words", 64'(words_seen - w0), 64'(HW));

        // Abort on word 1 of entry 1, then a clean one-entry drain
        w0 = words_seen; d0 = done_cnt; c = 0;
        start_drain(3);
        while (words_seen - w0 < HW + 4 && c < 100) begin
            step();
            c++;
        end
        chk("abort_reached_point", 64'(words_seen - w0), 64'(HW + 4));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid_low", 64'(out_vld), 64'(0));
        chk("abort_busy_low", 64'(busy), 64'(0));
        chk("abort_words_left", 64'(exp_w.size()), 64'(5));
        chk("abort_reads_left", 64'(exp_a.size()), 64'(1));
        exp_w.delete();
        exp_a.delete();
        repeat (3) step();
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        w0 = words_seen;
        start_drain(1);
        wait_done(40, "after_abort_done");
        step();
        chk("after_abort_words", 64'(words_seen - w0), 64'(3 + HW));
        chk("after_abort_queue", 64'(exp_w.size()), 64'(0));

        // Reset asserted in WAIT
        start_drain(2);
        repeat (HW + 1) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_bram_en", 64'(bram_en), 64'(0));
        chk("rstw_out_vld", 64'(out_vld), 64'(0));
        chk("rstw_out_data", 64'(out_data), 64'(0));
        chk("rstw_busy", 64'(busy), 64'(0));
        chk("rstw_done", 64'(done), 64'(0));
        exp_w.delete();
        exp_a.delete();
        step();

        // Start asserted during SEND is ignored
        w0 = words_seen; d0 = done_cnt; c = 0;
        start_drain(1);
        while (!out_vld && c < 20) begin
            step();
            c++;
        end
        chk("send_reached", 64'(out_vld), 64'(1));
        start = 1'b1;
        num   = CW'(5);
        step();
        start = 1'b0;
        wait_done(40, "ign_start_done");
        repeat (4) step();
        chk("ign_start_words", 64'(words_seen - w0), 64'(3 + HW));
        chk("ign_start_queue", 64'(exp_w.size()), 64'(0));
        chk("ign_start_one_done", 64'(done_cnt - d0), 64'(1));
        chk("ign_start_idle", 64'(busy), 64'(0));

        // Full log; request above capacity is clamped to 12288 entries
        w0 = words_seen;
        start_drain(20000);
        wait_done(80000, "full_done");
        step();
        chk("full_words", 64'(words_seen - w0), 64'(36864 + HW));
        chk("full_last_addr", 64'(last_addr), 64'(16'hBFFC));
        chk("full_queue_empty", 64'(exp_w.size()), 64'(0));
        chk("full_reads_empty", 64'(exp_a.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_log_drain.md
Name: axi_log_drain

Overview:
- Readout stage downstream of the AXI BRAM logger.
- After a start command, reads a given number of 96-bit log entries (timestamp, AXI address, AXI id/len) from the logger BRAM's second port.
- Serialises each entry into three 32-bit words on a valid/ready stream, which feeds the host-side readout FIFO.
- Replaces word-by-word host polling of the BRAM with a single bulk drain.

Parameters:
- LOGGING_DATA_BITW, 96, entry width; fixed at 3x32 bits.
- NUM_SER_BRAMS, 12, serial BRAM depth in 1024-entry units; must match the logger.
- LOG_ADDR_BITW, log2(1024*NUM_SER_BRAMS)+2, BRAM byte-word address width (derived).
- CNT_BITW, LOG_ADDR_BITW-1, entry-count width (derived).
- BRAM_RD_LAT, 1, BRAM read latency in cycles, 1..3.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous, active-high reset.
- Start_SI  in  1  begin drain; sampled only in IDLE.
- Abort_SI  in  1  cancel the drain in progress.
- NumEntries_DI  in  CNT_BITW  entries to drain (0..1024*NUM_SER_BRAMS); captured at start.
- BramEn_SO  out  1  BRAM read enable.
- BramAddr_DO  out  LOG_ADDR_BITW  BRAM address = entry index << 2.
- BramRdData_DI  in  LOGGING_DATA_BITW  BRAM read data, valid BRAM_RD_LAT cycles after BramEn_SO.
- OutData_DO  out  32  stream word.
- OutValid_SO  out  1  stream valid.
- OutReady_SI  in  1  stream ready.
- Busy_SO  out  1  high whenever state != IDLE.
- Done_SO  out  1  one-cycle pulse on completion.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; entry index 0; word-select 0.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: on Start_SI, latch NumEntries_DI into Remaining_S and clear the entry index.
  - Remaining 0 -> DONE.
  - Otherwise -> READ.
- READ (1 cycle): BramEn_SO=1, BramAddr_DO=Index<<2; go to WAIT.
- WAIT: lasts BRAM_RD_LAT cycles. On the last cycle, capture BramRdData_DI into a 96-bit hold register; go to SEND with word-select 0.
- SEND: OutValid_SO=1. The word is selected by word-select:
  - 0 -> hold[31:0] (id/len word)
  - 1 -> hold[63:32] (address)
  - 2 -> hold[95:64] (timestamp)
- On OutValid_SO && OutReady_SI:
  - word-select < 2: increment it.
  - word-select = 2: increment index and decrement remaining. Remaining now 0 -> DONE, else -> READ.
- While OutReady_SI is low, OutData_DO and OutValid_SO hold stable.
- DONE (1 cycle): Done_SO=1, then return to IDLE.
- Latency: with BRAM_RD_LAT=1, a Start_SI sampled at cycle t gives BramEn_SO at t+1 and the first OutValid_SO at t+3.
- Throughput with ready always high: 3+BRAM_RD_LAT+1 cycles per entry.
- BramEn_SO is high only in READ. The BRAM port is otherwise idle and must not be driven.
- Start_SI outside IDLE is ignored. NumEntries_DI changes after capture have no effect.
- Abort_SI, any non-IDLE state: go to IDLE next cycle.
  - OutValid_SO drops even with no handshake (allowed; the consumer flushes on Busy_SO fall).
  - Done_SO is not pulsed.
  - Abort takes priority over a simultaneous handshake.
- NumEntries_DI above 1024*NUM_SER_BRAMS is clamped to 1024*NUM_SER_BRAMS.
- The index never wraps within one drain; the final address is (N-1)<<2.
- Rst_RI mid-drain: IDLE next cycle; all outputs 0.

Optional Feature:
- Macro: AXI_LOG_DRAIN_HEADER_EN.
- Defined:
  - Before the first entry, SEND emits one header word {16'hB10C, NumEntries zero-extended to 16 bits}.
  - This happens even when N=0 (header, then DONE).
  - Header uses the same handshake; Abort_SI applies during it.
- Undefined: no header; the stream carries 3N words exactly.

Test Plan:
- Logger BRAM preloaded with 2 entries: e0={32'h10,32'h8000_0040,32'h0000_0305}, e1={32'h11,32'h8000_1000,32'h0000_0F07}; N=2, ready=1 -> words 0x305, 0x80000040, 0x10, 0xF07, 0x80001000, 0x11; one Done pulse; BramAddr_DO 0 then 4.
- Same data, OutReady_SI toggling 1/0 each cycle and held low 5 cycles on word 1 -> same 6 words, data stable while stalled, no duplicates or drops.
- N=0 -> Done_SO one cycle after Start; OutValid_SO and BramEn_SO never assert (with macro: exactly the header word 0xB10C0000 first).
- N=12288 (full log), BRAM_RD_LAT=2 -> 36864 words; last BramAddr_DO 0xBFFC; Done once; Busy_SO falls on the cycle after Done.
- N=3, Abort_SI asserted while word-select=1 of entry 1 -> IDLE next cycle, OutValid_SO=0, no Done; a new Start with N=1 drains entry 0 correctly.
- Rst_RI asserted during WAIT, and Start_SI asserted during SEND -> reset: all outputs 0 next cycle; Start during SEND: ignored, with the word count unchanged.
